fb_write_arbiter: RTL and testbench
===================================

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 SHALL provide parameter ADDR_W, default 17, framebuffer word-address width.
REQ-002 SHALL provide parameter DATA_W, default 8, pixel data width.
REQ-003 SHALL provide parameter FB_DEPTH, default 76800, number of valid framebuffer words (320x240).
REQ-004 SHALL have port clock  in  1  single clock for all state.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports req0/req1  in  1  write request from CPU 0 / CPU 1.
REQ-007 SHALL have ports addr0/addr1  in  ADDR_W  write address per requester.
REQ-008 SHALL have ports wdata0/wdata1  in  DATA_W  write data per requester.
REQ-009 SHALL have ports done0/done1  in  1  per-CPU program-finished flag (level).
REQ-010 SHALL have port start  in  1  one-cycle pulse that opens a new frame.
REQ-011 SHALL have ports gnt0/gnt1  out  1  write accepted this cycle.
REQ-012 SHALL have ports mem_we/mem_addr/mem_wdata  out  1/ADDR_W/DATA_W  registered framebuffer write port.
REQ-013 SHALL have ports frame_ready  out  1, busy  out  1, addr_err  out  1.

Function
REQ-014 SHALL implement states IDLE, RUN, DRAIN, READY.
REQ-015 IDLE->RUN on start; RUN->DRAIN when both sticky done flags set; DRAIN->READY after exactly one cycle; READY->RUN on start.
REQ-016 SHALL latch done0/done1 into sticky flags only in RUN; flags clear on start.
REQ-017 SHALL assert at most one of gnt0/gnt1 per cycle, combinationally, only in RUN.
REQ-018 Requester holds req/addr/wdata stable until its gnt is high; a high gnt consumes exactly one write.
REQ-019 Both req high: grant the requester not granted most recently; after reset, last-granted = 1 (req0 wins first).
REQ-020 Single req high: grant it regardless of history.
REQ-021 On grant with addr < FB_DEPTH: next cycle mem_we=1, mem_addr/mem_wdata = granted addr/wdata (latency 1).
REQ-022 On grant with addr >= FB_DEPTH: still grant, keep mem_we=0, set sticky addr_err (cleared on start).
REQ-023 Requests received in IDLE, DRAIN, READY SHALL be ignored (no gnt, no write).
REQ-024 Requests still served in RUN after own done flag latched, until the other CPU's done ends RUN.
REQ-025 busy=1 in RUN and DRAIN; frame_ready=1 only in READY.
REQ-026 start in RUN or DRAIN SHALL be ignored.

Reset
REQ-027 Reset SHALL force state IDLE, last-granted=1, sticky dones=0, addr_err=0, mem_we=0, mem_addr=0, mem_wdata=0, frame_ready=0, busy=0.
REQ-028 Reset mid-write SHALL drop the pending registered write (mem_we low from reset assertion).

Configuration
REQ-029 Macro FB_ARB_FIXED_PRIO_EN: defined -> req0 always wins a collision, last-granted unused.
REQ-030 Undefined -> round-robin per REQ-019.

Structure
REQ-031 Package fb_arb_pkg SHALL hold state enum, FB_DEPTH default and ADDR_W/DATA_W defaults.
REQ-032 Sub-module rr_pick2 SHALL hold the two-input grant selection and last-granted pointer.

Verification
REQ-033 Reset, start, req0 only addr=5 data=0x3C -> gnt0 same cycle; next cycle mem_we=1, mem_addr=5, mem_wdata=0x3C.
REQ-034 Both req held 4 cycles -> gnt sequence 0,1,0,1 (undefined macro); 0,0,0,0 with FB_ARB_FIXED_PRIO_EN.
REQ-035 req1 addr=76800 -> gnt1=1, mem_we stays 0, addr_err=1 until next start.
REQ-036 done0 then done1 two cycles later -> busy 1, one DRAIN cycle, frame_ready=1; start -> frame_ready=0, RUN.
REQ-037 Reset asserted the cycle after a grant -> mem_we=0 immediately, state IDLE, req ignored until start.

Source files
------------

// File: rtl/fb_arb_pkg.sv
// Shared types and default sizes for the framebuffer write arbiter.
// Optional build macro: FB_ARB_FIXED_PRIO_EN makes req0 win every collision.
package fb_arb_pkg;
  localparam int ADDR_W_DEF   = 17;
  localparam int DATA_W_DEF   = 8;
  localparam int FB_DEPTH_DEF = 76800;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_READY = 2'd3
  } fb_state_t;
endpackage

// File: rtl/rr_pick2.sv
// Two-input grant picker with a last-granted pointer.
// FB_ARB_FIXED_PRIO_EN defined: req0 always wins a collision.
// Undefined: a collision goes to the requester not granted most recently.
module rr_pick2 (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);
  // 1 means requester 1 was granted most recently; reset value lets req0 win first
  logic last;

  // Combinational grant selection, only while enabled
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (en) begin
`ifdef FB_ARB_FIXED_PRIO_EN
      gnt0 = req0;
      gnt1 = req1 & ~req0;
`else
      if (req0 && req1) begin
        gnt0 = last;
        gnt1 = ~last;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
`endif
    end
  end

  // Track which requester was served last
  always_ff @(posedge clock or posedge reset) begin
    if (reset)     last <= 1'b1;
    else if (gnt0) last <= 1'b0;
    else if (gnt1) last <= 1'b1;
  end
endmodule

// File: rtl/fb_write_arbiter.sv
// Framebuffer write arbiter: two CPUs share one registered write port
// during a frame; the frame ends once both CPUs have reported done.
// Optional build macro: FB_ARB_FIXED_PRIO_EN (fixed req0 priority).
module fb_write_arbiter
  import fb_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int FB_DEPTH = FB_DEPTH_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              done0,
  input  logic              done1,
  input  logic              start,
  output logic              gnt0,
  output logic              gnt1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              frame_ready,
  output logic              busy,
  output logic              addr_err
);
  // One extra bit so FB_DEPTH up to 2**ADDR_W compares correctly
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(FB_DEPTH);

  fb_state_t         state;
  logic              d0_s, d1_s;
  logic              run, start_acc, gnt_any, addr_ok, wr_ok, bad_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign run       = (state == ST_RUN);
  // start only opens a frame from IDLE or READY
  assign start_acc = start & ((state == ST_IDLE) | (state == ST_READY));

  rr_pick2 u_pick (
    .clock (clock),
    .reset (reset),
    .en    (run),
    .req0  (req0),
    .req1  (req1),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  assign gnt_any   = gnt0 | gnt1;
  assign sel_addr  = gnt1 ? addr1  : addr0;
  assign sel_wdata = gnt1 ? wdata1 : wdata0;
  assign addr_ok   = ({1'b0, sel_addr} < DEPTH_W);
  assign wr_ok     = gnt_any & addr_ok;
  assign bad_wr    = gnt_any & ~addr_ok;

  // Registered write port; out-of-range grants are consumed but flagged
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      addr_err  <= 1'b0;
    end else begin
      mem_we <= wr_ok;
      if (wr_ok) begin
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
      end
      if (start_acc)   addr_err <= 1'b0;
      else if (bad_wr) addr_err <= 1'b1;
    end
  end

  // Frame FSM with sticky done flags and registered status outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      d0_s        <= 1'b0;
      d1_s        <= 1'b0;
      busy        <= 1'b0;
      frame_ready <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state <= ST_RUN;
          busy  <= 1'b1;
          d0_s  <= 1'b0;
          d1_s  <= 1'b0;
        end
        ST_RUN: begin
          d0_s <= d0_s | done0;
          d1_s <= d1_s | done1;
          if (d0_s && d1_s) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          state       <= ST_READY;
          busy        <= 1'b0;
          frame_ready <= 1'b1;
        end
        ST_READY: if (start) begin
          state       <= ST_RUN;
          busy        <= 1'b1;
          frame_ready <= 1'b0;
          d0_s        <= 1'b0;
          d1_s        <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter with a frame-level reference model.
module tb_fb_write_arbiter;
  localparam int AW = 17;
  localparam int DW = 8;
  localparam int DEPTH = 76800;

  logic          clock, reset;
  logic          req0, req1, done0, done1, start;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, mem_we, frame_ready, busy, addr_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  int checks = 0;
  int errors = 0;

  fb_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FB_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .done0(done0), .done1(done1),
    .start(start), .gnt0(gnt0), .gnt1(gnt1), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .frame_ready(frame_ready), .busy(busy), .addr_err(addr_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 frame open, 2 drain, 3 frame ready
  int            m_phase;
  bit            m_last, m_d0, m_d1, m_err, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;

  // Which requester the rules say is served right now (bit0 = CPU0, bit1 = CPU1)
  function automatic logic [1:0] model_gnt();
    if (m_phase != 1) return 2'b00;
    if (req0 && req1) begin
`ifdef FB_ARB_FIXED_PRIO_EN
      return 2'b01;
`else
      return m_last ? 2'b01 : 2'b10;
`endif
    end
    return {req1, req0};
  endfunction

  always @(posedge clock or posedge reset) begin : mdl
    logic [1:0] g;
    int a, ph;
    bit d0, d1, er, we;
    if (reset) begin
      m_phase <= 0; m_last <= 1'b1; m_d0 <= 0; m_d1 <= 0;
      m_err <= 0; m_we <= 0; m_addr <= '0; m_wdata <= '0;
    end else begin
      g  = model_gnt();
      a  = g[1] ? int'(addr1) : int'(addr0);
      ph = m_phase; d0 = m_d0; d1 = m_d1; er = m_err; we = 0;
      if (g != 2'b00) begin
        m_last <= g[1];
        if (a < DEPTH) begin
          we = 1;
          m_addr  <= g[1] ? addr1 : addr0;
          m_wdata <= g[1] ? wdata1 : wdata0;
        end else er = 1;
      end
      if (m_phase == 0 || m_phase == 3) begin
        if (start) begin ph = 1; d0 = 0; d1 = 0; er = 0; end
      end else if (m_phase == 1) begin
        if (m_d0 && m_d1) ph = 2;
        d0 = m_d0 | done0;
        d1 = m_d1 | done1;
      end else ph = 3;
      m_phase <= ph; m_d0 <= d0; m_d1 <= d1; m_err <= er; m_we <= we;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clock) begin
    logic [1:0] g;
    g = model_gnt();
    chk("m_gnt0", gnt0, g[0]);
    chk("m_gnt1", gnt1, g[1]);
    chk("m_we", mem_we, m_we);
    chk("m_addr", mem_addr, m_addr);
    chk("m_wdata", mem_wdata, m_wdata);
    chk("m_busy", busy, (m_phase == 1 || m_phase == 2));
    chk("m_ready", frame_ready, (m_phase == 3));
    chk("m_err", addr_err, m_err);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [3:0] gs;
  logic [3:0] gs_exp;

  initial begin
    reset = 1'b1; req0 = 0; req1 = 0; done0 = 0; done1 = 0; start = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    step; step;
    @(negedge clock);
    chk("rst_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", frame_ready, 0);
    chk("rst_err", addr_err, 0);
    chk("rst_addr", mem_addr, 0);

    // request while idle is ignored
    step; reset = 0; req0 = 1; addr0 = 17'd7; wdata0 = 8'h11;
    @(negedge clock); chk("idle_gnt0", gnt0, 0);
    step; req0 = 0; start = 1;
    step; start = 0; req0 = 1; addr0 = 17'd5; wdata0 = 8'h3C;
    @(negedge clock); chk("first_gnt0", gnt0, 1); chk("first_gnt1", gnt1, 0);
    step; req0 = 0;
    @(negedge clock);
    chk("first_we", mem_we, 1); chk("first_addr", mem_addr, 5); chk("first_data", mem_wdata, 8'h3C);

    // out-of-range address
    step; req1 = 1; addr1 = 17'd76800; wdata1 = 8'h77;
    @(negedge clock); chk("oob_gnt1", gnt1, 1);
    step; req1 = 0;
    @(negedge clock); chk("oob_we", mem_we, 0); chk("oob_err", addr_err, 1);

    // collisions for four cycles, with an ignored start in the middle
    step; req0 = 1; req1 = 1; addr0 = 17'd10; wdata0 = 8'hA0; addr1 = 17'd20; wdata1 = 8'hB0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      gs[i] = gnt1;
      step;
      start = (i == 0);
    end
    req0 = 0; req1 = 0; start = 0;
`ifdef FB_ARB_FIXED_PRIO_EN
    gs_exp = 4'b0000;
`else
    gs_exp = 4'b1010;
`endif
    chk("collide_seq", gs, gs_exp);
    @(negedge clock);
`ifdef FB_ARB_FIXED_PRIO_EN
    chk("collide_last_addr", mem_addr, 10);
`else
    chk("collide_last_addr", mem_addr, 20);
`endif
    chk("err_held", addr_err, 1);
    chk("run_busy", busy, 1);

    // frame end: done0, still served, done1 two cycles later
    step; done0 = 1;
    step; req0 = 1; addr0 = 17'd30; wdata0 = 8'h5A;
    @(negedge clock); chk("post_done_gnt0", gnt0, 1);
    step; req0 = 0; done1 = 1;
    step;
    @(negedge clock); chk("c3_busy", busy, 1); chk("c3_ready", frame_ready, 0);
    step; start = 1;
    @(negedge clock); chk("drain_busy", busy, 1); chk("drain_ready", frame_ready, 0);
    step; start = 0; req1 = 1; addr1 = 17'd3; wdata1 = 8'h33;
    @(negedge clock); chk("ready_flag", frame_ready, 1); chk("ready_busy", busy, 0); chk("ready_gnt1", gnt1, 0);
    step; done0 = 0; done1 = 0;
    step; start = 1;
    step; start = 0;
    @(negedge clock);
    chk("restart_ready", frame_ready, 0); chk("restart_busy", busy, 1);
    chk("restart_err", addr_err, 0); chk("restart_gnt1", gnt1, 1);
    step; req1 = 0;

    // reset right after a grant drops the pending write
    step; req0 = 1; addr0 = 17'd40; wdata0 = 8'h55;
    @(negedge clock); chk("pre_rst_gnt0", gnt0, 1);
    step; reset = 1;
    @(negedge clock); chk("rst_mid_we", mem_we, 0); chk("rst_mid_busy", busy, 0);
    step; reset = 0;
    @(negedge clock); chk("post_rst_gnt0", gnt0, 0);
    step; start = 1;
    @(negedge clock); chk("start_cycle_gnt0", gnt0, 0);
    step; start = 0;
    @(negedge clock); chk("rerun_gnt0", gnt0, 1);
    step; req0 = 0;
    @(negedge clock); chk("rerun_we", mem_we, 1); chk("rerun_addr", mem_addr, 40);
    step; step;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
